// File: rtl/slice_order_arbiter.sv
// Merges results from several 2nd-level parsers back into original slice order.
// An order queue records which parser got each slice; only the head parser drains.
module slice_order_arbiter #(
  parameter int NUM_PARSER = 6,
  parameter int RES_W      = 64,
  parameter int DEPTH      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          issue_valid,
  input  logic [NUM_PARSER-1:0]         issue_grant,
  input  logic [NUM_PARSER-1:0]         par_valid,
  input  logic [NUM_PARSER*RES_W-1:0]   par_data,
  input  logic [NUM_PARSER-1:0]         par_last,
  output logic [NUM_PARSER-1:0]         par_ready,
  output logic                          out_valid,
  output logic [RES_W-1:0]              out_data,
  output logic                          out_last,
  input  logic                          out_ready,
  output logic                          stop,
  output logic [$clog2(DEPTH):0]        occupancy,
  output logic [15:0]                   slices_done,
  output logic                          err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int IDX_W = (NUM_PARSER > 1) ? $clog2(NUM_PARSER) : 1;

  logic [IDX_W-1:0] order_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [IDX_W-1:0] head, grant_idx;
  logic [OCC_W-1:0] occ_next;
  logic             nonempty, full, grant_onehot, pop, do_push, err_set;

  assign nonempty     = (occupancy != '0);
  assign full         = (occupancy == OCC_W'(DEPTH));
  assign head         = order_q[rd_ptr];
  assign grant_onehot = ($countones(issue_grant) == 1);
  assign pop          = out_valid & out_ready & out_last;
  assign do_push      = issue_valid & grant_onehot & (~full | pop);
  assign err_set      = issue_valid & (~grant_onehot | (full & ~pop));

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_PARSER; i++)
      if (issue_grant[i]) grant_idx = IDX_W'(i);
  end

  // Only the head parser is ever looked at; everyone else waits its turn.
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    par_ready = '0;
    for (int i = 0; i < NUM_PARSER; i++) begin
      if (head == IDX_W'(i)) begin
        out_valid    = nonempty & par_valid[i];
        out_data     = par_data[i*RES_W +: RES_W];
        out_last     = par_last[i];
        par_ready[i] = nonempty & out_ready;
      end
    end
  end

  always_comb begin
    occ_next = occupancy;
    if (do_push && !pop)
      occ_next = occupancy + OCC_W'(1);
    else if (!do_push && pop)
      occ_next = occupancy - OCC_W'(1);
  end

  always_ff @(posedge clk) begin
    if (do_push) order_q[wr_ptr] <= grant_idx;
  end

  // stop asserts two entries early so the distributor's one-cycle lag cannot overflow us.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      occupancy   <= '0;
      stop        <= 1'b0;
      slices_done <= '0;
      err         <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) begin
        rd_ptr      <= rd_ptr + PTR_W'(1);
        slices_done <= slices_done + 16'd1;
      end
      occupancy <= occ_next;
      stop      <= (occ_next >= OCC_W'(DEPTH - 2));
      if (err_set) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_slice_order_arbiter.sv
// Bench for slice_order_arbiter: table vectors, directed corner sequences and
// random traffic checked against a queue-based reference model.
module tb_slice_order_arbiter;

  localparam int NP    = 6;
  localparam int RW    = 64;
  localparam int DEPTH = 16;

  logic          clk;
  logic          rst_n;
  logic          iv;
  logic [NP-1:0] ig, pv, pl, par_ready;
  logic [NP*RW-1:0] par_data;
  logic          ordy;
  logic          out_valid, out_last, stop, err;
  logic [RW-1:0] out_data;
  logic [4:0]    occupancy;
  logic [15:0]   slices_done;
  logic [RW-1:0] pdata [NP];

  int errors = 0;
  int checks = 0;
  int words_seen;

  // Reference model: the order queue as a plain SV queue of parser numbers.
  int q[$];
  int m_done;
  bit m_err;
  bit m_stop;

  slice_order_arbiter #(.NUM_PARSER(NP), .RES_W(RW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(iv), .issue_grant(ig),
    .par_valid(pv), .par_data(par_data), .par_last(pl), .par_ready(par_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(ordy), .stop(stop), .occupancy(occupancy),
    .slices_done(slices_done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    par_data = '0;
    for (int i = 0; i < NP; i++) par_data[i*RW +: RW] = pdata[i];
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [NP-1:0] g);
    int r = 0;
    for (int i = 0; i < NP; i++) if (g[i]) r = i;
    return r;
  endfunction

  task automatic apply_stimulus(input bit v, input logic [NP-1:0] g, input logic [NP-1:0] valid,
                                input logic [NP-1:0] last, input bit rdy);
    iv = v; ig = g; pv = valid; pl = last; ordy = rdy;
  endtask

  // One clock: check combinational outputs, clock, advance model, check registers.
  task automatic step();
    int head;
    bit nonempty, exp_ov, pop, onehot, full;
    logic [NP-1:0] exp_pr;
    #1;
    nonempty = (q.size() != 0);
    head     = nonempty ? q[0] : 0;
    exp_ov   = nonempty && pv[head];
    exp_pr   = (nonempty && ordy) ? (NP'(1) << head) : '0;
    check_output("out_valid", out_valid, exp_ov);
    check_output("par_ready", par_ready, exp_pr);
    if (exp_ov) begin
      check_output("out_data", out_data, pdata[head]);
      check_output("out_last", out_last, pl[head]);
    end
    if (out_valid && ordy) words_seen++;
    @(posedge clk);
    pop    = exp_ov && ordy && pl[head];
    onehot = ($countones(ig) == 1);
    full   = (q.size() == DEPTH);
    if (pop) begin
      void'(q.pop_front());
      m_done = (m_done + 1) % 65536;
    end
    if (iv) begin
      if (!onehot || (full && !pop)) m_err = 1'b1;
      else q.push_back(idx_of(ig));
    end
    m_stop = (q.size() >= DEPTH - 2);
    #1;
    check_output("occupancy", occupancy, q.size());
    check_output("stop", stop, m_stop);
    check_output("err", err, m_err);
    check_output("slices_done", slices_done, m_done);
    @(negedge clk);
  endtask

  task automatic do_reset();
    apply_stimulus(0, '0, '0, '0, 0);
    rst_n = 1'b0;
    #1;
    check_output("rst_occupancy", occupancy, 0);
    check_output("rst_err", err, 0);
    check_output("rst_stop", stop, 0);
    check_output("rst_slices_done", slices_done, 0);
    check_output("rst_out_valid", out_valid, 0);
    check_output("rst_par_ready", par_ready, 0);
    q.delete();
    m_done = 0; m_err = 1'b0; m_stop = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit            iv;
    logic [NP-1:0] ig, pv, pl;
    bit            ordy;
    bit            exp_ov;
    int            exp_idx;
    int            exp_occ;
    int            exp_done;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int w;
    // Issue 0,1,2; parsers answer 2, then 1, then 0; output must still be 0,1,2.
    tbl[0] = '{1, 6'b000001, 6'b000000, 6'b000000, 1, 0, 0, 1, 0};
    tbl[1] = '{1, 6'b000010, 6'b000000, 6'b000000, 1, 0, 0, 2, 0};
    tbl[2] = '{1, 6'b000100, 6'b000100, 6'b000100, 1, 0, 0, 3, 0};
    tbl[3] = '{0, 6'b000000, 6'b000110, 6'b000110, 1, 0, 0, 3, 0};
    tbl[4] = '{0, 6'b000000, 6'b000111, 6'b000111, 1, 1, 0, 2, 1};
    tbl[5] = '{0, 6'b000000, 6'b000111, 6'b000111, 1, 1, 1, 1, 2};
    tbl[6] = '{0, 6'b000000, 6'b000111, 6'b000111, 1, 1, 2, 0, 3};
    tbl[7] = '{0, 6'b000000, 6'b000111, 6'b000111, 1, 0, 0, 0, 3};

    rst_n = 1'b1;
    for (int i = 0; i < NP; i++) pdata[i] = 64'hC0DE_0000_0000_0000 + 64'(i);
    apply_stimulus(0, '0, '0, '0, 0);
    @(negedge clk);
    do_reset();

    for (int k = 0; k < 8; k++) begin
      apply_stimulus(tbl[k].iv, tbl[k].ig, tbl[k].pv, tbl[k].pl, tbl[k].ordy);
      #1;
      check_output("tbl_out_valid", out_valid, tbl[k].exp_ov);
      if (tbl[k].exp_ov)
        check_output("tbl_out_data", out_data, 64'hC0DE_0000_0000_0000 + 64'(tbl[k].exp_idx));
      step();
      check_output("tbl_occupancy", occupancy, tbl[k].exp_occ);
      check_output("tbl_slices_done", slices_done, tbl[k].exp_done);
    end

    // Multi-word slice from parser 3 with out_ready toggling.
    apply_stimulus(1, 6'b001000, '0, '0, 1);
    step();
    w = 0;
    words_seen = 0;
    for (int c = 0; c < 7; c++) begin
      pdata[3] = 64'hBEEF_0000_0000_0000 + 64'(w);
      apply_stimulus(0, '0, 6'b001000, (w == 3) ? 6'b001000 : 6'b000000, (c % 2) == 0);
      step();
      if (ordy) w++;
    end
    check_output("multiword_words", words_seen, 4);
    check_output("multiword_done", slices_done, 4);
    check_output("multiword_occ", occupancy, 0);

    // Throttle: 14 issues with nothing draining.
    do_reset();
    for (int i = 0; i < 14; i++) begin
      apply_stimulus(1, NP'(1) << (i % 5), '0, '0, 0);
      step();
    end
    check_output("throttle_stop_set", stop, 1);
    apply_stimulus(0, '0, '1, '1, 1);
    step();
    check_output("throttle_stop_clear", stop, 0);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1, NP'(1) << (i % 5), '0, '0, 0);
      step();
    end
    check_output("full_occ", occupancy, 16);
    // Push and pop together while full.
    apply_stimulus(1, 6'b100000, '1, '1, 1);
    step();
    check_output("full_pushpop_occ", occupancy, 16);
    check_output("full_pushpop_err", err, 0);
    // Overflow push is dropped and flagged.
    apply_stimulus(1, 6'b100000, '0, '0, 0);
    step();
    check_output("overflow_occ", occupancy, 16);
    check_output("overflow_err", err, 1);
    for (int i = 0; i < 16; i++) begin
      apply_stimulus(0, '0, '1, '1, 1);
      step();
    end
    check_output("drain_occ", occupancy, 0);

    // Bad grant, then reset in the middle of traffic.
    do_reset();
    apply_stimulus(1, 6'b000011, '0, '0, 0);
    step();
    check_output("badgrant_err", err, 1);
    check_output("badgrant_occ", occupancy, 0);
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1, NP'(1) << i, '0, '0, 0);
      step();
    end
    check_output("prereset_occ", occupancy, 5);
    do_reset();
    apply_stimulus(1, 6'b010000, '0, '0, 0);
    step();
    check_output("postreset_push", occupancy, 1);

    // Random traffic at several issue rates.
    for (int seg = 0; seg < 4; seg++) begin
      do_reset();
      for (int c = 0; c < 400; c++) begin
        for (int i = 0; i < NP; i++) pdata[i] = {$urandom(), $urandom()};
        apply_stimulus($urandom_range(0, 99) < (15 + seg * 25),
                       ($urandom_range(0, 99) < 3) ? NP'($urandom()) : (NP'(1) << $urandom_range(0, NP-1)),
                       NP'($urandom()), NP'($urandom()), $urandom_range(0, 3) != 0);
        step();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/slice_order_arbiter.md
SLICE_ORDER_ARBITER -- requirements
Module: slice_order_arbiter

Interface
REQ-001 SHALL have parameter NUM_PARSER, default 6: number of 2nd-level parsers sharing the output port.
REQ-002 SHALL have parameter RES_W, default 64: width of one parser result word.
REQ-003 SHALL have parameter DEPTH, default 16: order-queue entries; power of two, DEPTH >= 4.
REQ-004 SHALL have port clk  input  1: the single clock; all state on its rising edge.
REQ-005 SHALL have port rst_n  input  1: reset; asynchronous assertion, active-low.
REQ-006 SHALL have port issue_valid  input  1: a slice was handed to a parser this cycle.
REQ-007 SHALL have port issue_grant  input  NUM_PARSER: one-hot parser that received the slice.
REQ-008 SHALL have port par_valid  input  NUM_PARSER: per-parser result word available.
REQ-009 SHALL have port par_data  input  NUM_PARSER*RES_W: parser i result in bits [i*RES_W +: RES_W].
REQ-010 SHALL have port par_last  input  NUM_PARSER: per-parser final word of the current slice.
REQ-011 SHALL have port par_ready  output  NUM_PARSER: result word of parser i consumed this cycle.
REQ-012 SHALL have port out_valid  output  1: out_data valid.
REQ-013 SHALL have port out_data  output  RES_W: merged result stream, original slice order.
REQ-014 SHALL have port out_last  output  1: final word of a slice.
REQ-015 SHALL have port out_ready  input  1: downstream accepts out_data.
REQ-016 SHALL have port stop  output  1: registered; throttles the slice distributor.
REQ-017 SHALL have port occupancy  output  $clog2(DEPTH)+1: slices issued but not yet fully drained.
REQ-018 SHALL have port slices_done  output  16: count of completed slices, wraps at 65535 -> 0.
REQ-019 SHALL have port err  output  1: sticky protocol-error flag.

Function
REQ-020 SHALL keep a FIFO of encoded parser indices (order queue), DEPTH entries, read/write pointers wrapping modulo DEPTH.
REQ-021 SHALL push the index of issue_grant when issue_valid=1, issue_grant is one-hot and the queue is not full, or is full with a pop in the same cycle.
REQ-022 SHALL NOT push and SHALL set err when issue_valid=1 and issue_grant is zero or not one-hot.
REQ-023 SHALL NOT push and SHALL set err when issue_valid=1 into a full queue with no simultaneous pop; no existing entry is overwritten.
REQ-024 SHALL define head as the queue's oldest entry; out_valid = (occupancy!=0) & par_valid[head], combinational.
REQ-025 SHALL drive out_data = par_data slice of head, out_last = par_last[head]; both don't-care when out_valid=0.
REQ-026 SHALL drive par_ready[head] = (occupancy!=0) & out_ready; all other par_ready bits 0.
REQ-027 SHALL pop the head when out_valid & out_ready & out_last; the next entry becomes head the following cycle.
REQ-028 SHALL allow push and pop in the same cycle; occupancy is then unchanged.
REQ-029 SHALL allow a slice issued to the head parser to enter the queue while that parser is still draining; no ordering bypass.
REQ-030 SHALL increment slices_done by 1 on every pop.
REQ-031 SHALL register stop <= (next occupancy >= DEPTH-2); the margin absorbs the distributor's one-cycle stop latency.
REQ-032 SHALL ignore par_valid, par_data and par_last of non-head parsers; results are never reordered or dropped.
REQ-033 SHALL hold err at 1 until reset once set.
REQ-034 SHALL accept a pop of a slice from a parser that ran empty mid-slice; it stalls with out_valid=0 until par_valid[head] returns.

Reset
REQ-035 SHALL, while rst_n=0, asynchronously clear both pointers, occupancy=0, stop=0, slices_done=0 and err=0; out_valid=0 and par_ready=0 follow from empty.
REQ-036 SHALL discard all queued order entries on reset assertion mid-operation; first push after release is honoured on the first rising edge with rst_n=1.

Verification
REQ-037 SHALL cover in-order merge: issue to parsers 0,1,2; parser 2 then 1 then 0 present single last words -> out_data order 0,1,2, slices_done=3.
REQ-038 SHALL cover multi-word slice: parser 3 presents 4 words (last on 4th) with out_ready toggling 1,0,1,… -> 4 words out in order, one pop, par_ready[3] only when out_ready=1.
REQ-039 SHALL cover throttle: DEPTH=16, 14 issues, no drain -> stop=1 the cycle after the 14th push; one pop -> stop=0 the cycle after.
REQ-040 SHALL cover overflow: 17 issues with no pop -> occupancy=16, err=1, the 17th index absent on drain.
REQ-041 SHALL cover simultaneous push/pop at occupancy=16 -> occupancy stays 16, err=0, FIFO order preserved.
REQ-042 SHALL cover bad grant and mid-run reset: issue_grant=6'b000011 -> err=1, no push; rst_n low for 1 cycle at occupancy=5 -> occupancy=0, err=0, stop=0.
